// File: rtl/bp_be_pkg.sv
// Shared types for the backend issue queue: instruction class tags and the stored entry layout.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_iq_plain  = 2'd0,
    e_iq_mem    = 2'd1,
    e_iq_serial = 2'd2
  } bp_be_iq_class_e;

  localparam int unsigned fe_queue_width_gp = 128;

  typedef struct packed {
    bp_be_iq_class_e                iq_class;
    logic [fe_queue_width_gp-1:0]   payload;
  } bp_be_iq_entry_s;

endpackage

// File: rtl/bp_be_iq_group_former.sv
// Combinational issue-group detector: masks the head entries by class so a group holds at most
// one mem op and a serialising op always issues alone.
module bp_be_iq_group_former
  import bp_be_pkg::*;
#(
  parameter int unsigned issue_width_p = 2
) (
  input  logic [issue_width_p-1:0][1:0] head_class_i,
  input  logic [issue_width_p-1:0]      avail_i,
  output logic [issue_width_p-1:0]      deq_v_o
);

  always_comb begin
    logic grp_open;
    logic seen_mem;
    logic is_mem;
    logic is_serial;
    deq_v_o    = '0;
    deq_v_o[0] = avail_i[0];
    seen_mem   = (head_class_i[0] == e_iq_mem);
    // A serial head closes the group after lane 0.
    grp_open   = avail_i[0] && (head_class_i[0] != e_iq_serial);
    for (int k = 1; k < issue_width_p; k++) begin
      is_mem    = (head_class_i[k] == e_iq_mem);
      is_serial = (head_class_i[k] == e_iq_serial);
      if (grp_open && avail_i[k] && !is_serial && !(is_mem && seen_mem)) begin
        deq_v_o[k] = 1'b1;
        seen_mem   = seen_mem | is_mem;
      end else begin
        grp_open = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bp_be_issue_queue_nwide.sv
// N-wide in-order issue queue between the FE queue and the BE scheduler. Flop storage so every
// head lane can be read in parallel; group formation is delegated to bp_be_iq_group_former.
module bp_be_issue_queue_nwide
  import bp_be_pkg::*;
#(
  parameter int unsigned issue_width_p    = 2,
  parameter int unsigned entries_p        = 8,
  parameter int unsigned entry_width_p    = 128,
  localparam int unsigned cnt_width_lp     = $clog2(entries_p + 1),
  localparam int unsigned deq_cnt_width_lp = $clog2(issue_width_p + 1),
  localparam int unsigned ptr_width_lp     = $clog2(entries_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [issue_width_p-1:0]               enq_v_i,
  input  logic [issue_width_p*entry_width_p-1:0] enq_data_i,
  input  logic [issue_width_p*2-1:0]             enq_class_i,
  output logic                                   enq_ready_o,
  output logic [issue_width_p-1:0]               deq_v_o,
  output logic [issue_width_p*entry_width_p-1:0] deq_data_o,
  input  logic [deq_cnt_width_lp-1:0]            deq_cnt_i,
  input  logic                                   flush_i,
  output logic [cnt_width_lp-1:0]                count_o
);

  logic [ptr_width_lp-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0]  count_q, count_d;
  logic                     ready_en_q;
  logic [1:0]               class_q   [entries_p];
  logic [entry_width_p-1:0] payload_q [entries_p];

  logic [deq_cnt_width_lp-1:0]    enq_cnt, enq_acc, deq_valid_cnt;
  logic [ptr_width_lp-1:0]        wr_idx   [issue_width_p];
  logic [ptr_width_lp-1:0]        head_idx [issue_width_p];
  logic [issue_width_p-1:0][1:0]  head_class;
  logic [issue_width_p-1:0]       avail;

  // Ready comes from the registered count only; ready_en_q holds it low until the first edge.
  assign enq_ready_o = ready_en_q && (count_q <= cnt_width_lp'(entries_p - issue_width_p));
  assign enq_acc     = enq_ready_o ? enq_cnt : '0;
  assign count_o     = count_q;

  always_comb begin
    enq_cnt       = '0;
    deq_valid_cnt = '0;
    for (int k = 0; k < issue_width_p; k++) begin
      enq_cnt       = enq_cnt + deq_cnt_width_lp'(enq_v_i[k]);
      deq_valid_cnt = deq_valid_cnt + deq_cnt_width_lp'(deq_v_o[k]);
      wr_idx[k]     = wr_ptr_q + ptr_width_lp'(k);
      head_idx[k]   = rd_ptr_q + ptr_width_lp'(k);
      head_class[k] = class_q[head_idx[k]];
      avail[k]      = (count_q > cnt_width_lp'(k));
      deq_data_o[k*entry_width_p +: entry_width_p] = payload_q[head_idx[k]];
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + ptr_width_lp'(enq_acc);
    rd_ptr_d = rd_ptr_q + ptr_width_lp'(deq_cnt_i);
    count_d  = count_q + cnt_width_lp'(enq_acc) - cnt_width_lp'(deq_cnt_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= 1'b1;
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < issue_width_p; k++) begin
      if (enq_ready_o && enq_v_i[k]) begin
        class_q[wr_idx[k]]   <= enq_class_i[2*k +: 2];
        payload_q[wr_idx[k]] <= enq_data_i[k*entry_width_p +: entry_width_p];
      end
    end
  end

  bp_be_iq_group_former #(
    .issue_width_p (issue_width_p)
  ) u_group_former (
    .head_class_i (head_class),
    .avail_i      (avail),
    .deq_v_o      (deq_v_o)
  );

  a_enq_contig: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    ((enq_v_i + issue_width_p'(1)) & enq_v_i) == '0);
  a_deq_cnt: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    deq_cnt_i <= deq_valid_cnt);
  a_count_max: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    count_q <= cnt_width_lp'(entries_p));

endmodule

// File: tb/tb_bp_be_issue_queue_nwide.sv
// Directed bench for the N-wide issue queue at W=2, E=8, 128-bit payloads.
module tb_bp_be_issue_queue_nwide;
  import bp_be_pkg::*;

  localparam int unsigned W  = 2;
  localparam int unsigned E  = 8;
  localparam int unsigned EW = 128;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [W-1:0]    enq_v;
  logic [W*EW-1:0] enq_data;
  logic [W*2-1:0]  enq_class;
  logic            enq_ready;
  logic [W-1:0]    deq_v;
  logic [W*EW-1:0] deq_data;
  logic [1:0]      deq_cnt;
  logic            flush;
  logic [3:0]      count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bp_be_issue_queue_nwide #(
    .issue_width_p (W),
    .entries_p     (E),
    .entry_width_p (EW)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .enq_v_i     (enq_v),
    .enq_data_i  (enq_data),
    .enq_class_i (enq_class),
    .enq_ready_o (enq_ready),
    .deq_v_o     (deq_v),
    .deq_data_o  (deq_data),
    .deq_cnt_i   (deq_cnt),
    .flush_i     (flush),
    .count_o     (count)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic [1:0] v, input bp_be_iq_class_e c0, input logic [127:0] d0,
                         input bp_be_iq_class_e c1, input logic [127:0] d1);
    enq_v     = v;
    enq_class = {c1, c0};
    enq_data  = {d1, d0};
  endtask

  task automatic check_head(input string tag, input logic [1:0] v, input logic [127:0] d0,
                            input logic [127:0] d1);
    check({tag, "_v"}, 128'(deq_v), 128'(v));
    if (v[0]) check({tag, "_d0"}, deq_data[0 +: EW], d0);
    if (v[1]) check({tag, "_d1"}, deq_data[EW +: EW], d1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    enq_v = '0; enq_data = '0; enq_class = '0; deq_cnt = '0; flush = 1'b0;
    #3;
    check("rst_count", 128'(count), 128'd0);
    check("rst_ready", 128'(enq_ready), 128'd0);
    check("rst_deq_v", 128'(deq_v), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("ready_before_edge", 128'(enq_ready), 128'd0);
    tick();
    check("ready_after_edge", 128'(enq_ready), 128'd1);

    // 1: fill with two plain ops per cycle, then drain in order
    for (int i = 0; i < 4; i++) begin
      set_enq(2'b11, e_iq_plain, 128'(2*i+1), e_iq_plain, 128'(2*i+2));
      tick();
      if (i == 2) begin
        check("t1_ready_at6", 128'(enq_ready), 128'd1);
        check("t1_count6", 128'(count), 128'd6);
      end
    end
    enq_v = '0;
    check("t1_ready_full", 128'(enq_ready), 128'd0);
    check("t1_count8", 128'(count), 128'd8);
    for (int i = 0; i < 4; i++) begin
      check_head("t1_drain", 2'b11, 128'(2*i+1), 128'(2*i+2));
      deq_cnt = 2'd2;
      tick();
    end
    deq_cnt = 2'd0;
    check("t1_empty_count", 128'(count), 128'd0);
    check("t1_empty_v", 128'(deq_v), 128'd0);

    // 2: mem limiting
    set_enq(2'b11, e_iq_plain, 128'h21, e_iq_mem, 128'h22);
    tick();
    set_enq(2'b01, e_iq_mem, 128'h23, e_iq_plain, 128'h0);
    tick();
    enq_v = '0;
    check("t2_count3", 128'(count), 128'd3);
    check_head("t2_pm", 2'b11, 128'h21, 128'h22);
    deq_cnt = 2'd2;
    set_enq(2'b01, e_iq_mem, 128'h24, e_iq_plain, 128'h0);
    tick();
    enq_v = '0; deq_cnt = 2'd0;
    check_head("t2_mm", 2'b01, 128'h23, 128'h0);
    deq_cnt = 2'd1;
    tick();
    check_head("t2_m", 2'b01, 128'h24, 128'h0);
    tick();
    deq_cnt = 2'd0;
    check("t2_empty", 128'(count), 128'd0);

    // 3: serial issues alone
    set_enq(2'b11, e_iq_plain, 128'h31, e_iq_serial, 128'h32);
    tick();
    set_enq(2'b01, e_iq_plain, 128'h33, e_iq_plain, 128'h0);
    tick();
    enq_v = '0;
    check_head("t3_ps", 2'b01, 128'h31, 128'h0);
    deq_cnt = 2'd1;
    tick();
    check_head("t3_s", 2'b01, 128'h32, 128'h0);
    tick();
    check_head("t3_p", 2'b01, 128'h33, 128'h0);
    check("t3_count1", 128'(count), 128'd1);
    tick();
    deq_cnt = 2'd0;

    // 4: write pointer is now 7, so this pair splits across the wrap
    set_enq(2'b11, e_iq_plain, 128'h41, e_iq_plain, 128'h42);
    tick();
    enq_v = '0;
    check("t4_count", 128'(count), 128'd2);
    check_head("t4_wrap", 2'b11, 128'h41, 128'h42);
    deq_cnt = 2'd2;
    tick();
    deq_cnt = 2'd0;
    check("t4_empty", 128'(count), 128'd0);

    // 5: full, simultaneous deq and rejected enq
    for (int i = 0; i < 4; i++) begin
      set_enq(2'b11, e_iq_plain, 128'(8'h51 + 2*i), e_iq_plain, 128'(8'h52 + 2*i));
      tick();
    end
    check("t5_count8", 128'(count), 128'd8);
    check("t5_ready0", 128'(enq_ready), 128'd0);
    check_head("t5_head", 2'b11, 128'h51, 128'h52);
    set_enq(2'b11, e_iq_plain, 128'h5a, e_iq_plain, 128'h5b);
    deq_cnt = 2'd2;
    tick();
    enq_v = '0; deq_cnt = 2'd0;
    check("t5_count6", 128'(count), 128'd6);
    check("t5_ready1", 128'(enq_ready), 128'd1);
    check_head("t5_next", 2'b11, 128'h53, 128'h54);

    // 6: flush beats enq and deq; then async reset mid-stream
    set_enq(2'b11, e_iq_plain, 128'h6a, e_iq_plain, 128'h6b);
    deq_cnt = 2'd1;
    flush   = 1'b1;
    #1;
    check("t6_preflush_v", 128'(deq_v), 128'd3);
    tick();
    enq_v = '0; deq_cnt = 2'd0; flush = 1'b0;
    check("t6_flush_count", 128'(count), 128'd0);
    check("t6_flush_v", 128'(deq_v), 128'd0);
    set_enq(2'b11, e_iq_plain, 128'h61, e_iq_plain, 128'h62);
    tick();
    enq_v = '0;
    check("t6_refill", 128'(count), 128'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_arst_count", 128'(count), 128'd0);
    check("t6_arst_v", 128'(deq_v), 128'd0);
    check("t6_arst_ready", 128'(enq_ready), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("t6_post_ready", 128'(enq_ready), 128'd1);
    check("t6_post_count", 128'(count), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
